// File: rtl/pong_pkg.sv
// Shared definitions for the pong video pipeline.
// Contents: default paddle geometry, the paddle window state type and a
// ceil(log2) helper for sizing counters from parameters.
package pong_pkg;

  localparam int PADDLE_HEIGHT_DEFAULT   = 16;
  localparam int PADDLE_SEG_BITS_DEFAULT = 3;

  typedef enum logic {
    WIN_IDLE   = 1'b0,
    WIN_ACTIVE = 1'b1
  } win_state_t;

  // Smallest r with 2**r >= value; usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/paddle_window_channel.sv
// One paddle vertical-window channel.
// A rising edge on start arms a window that lasts HEIGHT scanline ticks.
// Ports:
//   clk         pixel clock
//   reset       synchronous, active-high
//   line_tick   one-cycle pulse per scanline
//   frame_start one-cycle pulse at top of frame, aborts the window
//   start       level from the vertical comparator; rising edge arms
//   active      window-active flag (registered)
//   segment     upper SEG_BITS of the line counter (registered)
//   done        one-cycle pulse when a window completes (registered)
//
// state      | meaning
// -----------+-----------------------------------------------------
// WIN_IDLE   | no window; waiting for a start edge
// WIN_ACTIVE | window open; counting line ticks 0..HEIGHT-1
module paddle_window_channel
  import pong_pkg::*;
#(
  parameter int HEIGHT    = PADDLE_HEIGHT_DEFAULT,
  parameter int SEG_BITS  = PADDLE_SEG_BITS_DEFAULT,
  parameter int RETRIGGER = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                line_tick,
  input  logic                frame_start,
  input  logic                start,
  output logic                active,
  output logic [SEG_BITS-1:0] segment,
  output logic                done
);

  localparam int CNT_W = clog2(HEIGHT);
  localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(HEIGHT - 1);

  win_state_t       state;
  logic [CNT_W-1:0] count;
  logic             start_q;
  logic             start_edge;
  logic             can_arm;

  assign start_edge = start & ~start_q;
  assign can_arm    = (state == WIN_IDLE) || (RETRIGGER != 0);

  // Arming outranks abort and counting so a fresh edge is never lost.
  // start_q resets high: a start already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= WIN_IDLE;
      active  <= 1'b0;
      count   <= '0;
      done    <= 1'b0;
      start_q <= 1'b1;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      if (start_edge && can_arm) begin
        state  <= WIN_ACTIVE;
        active <= 1'b1;
        count  <= '0;
      end else if (frame_start) begin
        state  <= WIN_IDLE;
        active <= 1'b0;
        count  <= '0;
      end else if (line_tick && (state == WIN_ACTIVE)) begin
        if (count == LAST_LINE) begin
          state  <= WIN_IDLE;
          active <= 1'b0;
          count  <= '0;
          done   <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  // Each segment spans HEIGHT >> SEG_BITS lines.
  assign segment = count[CNT_W-1 -: SEG_BITS];

endmodule

// File: rtl/paddle_window_gen.sv
// Multi-channel paddle vertical-window generator.
// Ports:
//   clk, reset               pixel clock, synchronous active-high reset
//   line_tick, frame_start   shared scanline / frame pulses
//   start[NUM_CH]            per-channel arm level
//   active[NUM_CH]           per-channel window-active flag
//   segment[NUM_CH*SEG_BITS] channel i at [i*SEG_BITS +: SEG_BITS]
//   done[NUM_CH]             per-channel window-complete pulse
module paddle_window_gen
  import pong_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int HEIGHT    = PADDLE_HEIGHT_DEFAULT,
  parameter int SEG_BITS  = PADDLE_SEG_BITS_DEFAULT,
  parameter int RETRIGGER = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       line_tick,
  input  logic                       frame_start,
  input  logic [NUM_CH-1:0]          start,
  output logic [NUM_CH-1:0]          active,
  output logic [NUM_CH*SEG_BITS-1:0] segment,
  output logic [NUM_CH-1:0]          done
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    paddle_window_channel #(
      .HEIGHT    (HEIGHT),
      .SEG_BITS  (SEG_BITS),
      .RETRIGGER (RETRIGGER)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .line_tick   (line_tick),
      .frame_start (frame_start),
      .start       (start[i]),
      .active      (active[i]),
      .segment     (segment[i*SEG_BITS +: SEG_BITS]),
      .done        (done[i])
    );
  end

endmodule
